fft_frame_counter: RTL and testbench

FFT_FRAME_COUNTER -- requirements
Module: fft_frame_counter

---
 rtl/fft_cnt_pkg.sv | 13 +
 rtl/fft_frame_counter.sv | 103 ++++++++++
 tb/tb_fft_frame_counter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fft_cnt_pkg.sv
// Shared constants for the FFT frame counter: FSM state encoding and run modes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fft_cnt_pkg;

    // A single state bit means exactly one of IDLE/RUN is active by construction.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/fft_frame_counter.sv
// Counts accepted samples into frames of thresh+1 samples, one-shot or auto-reload.
// Latency: cnt/full/frame_cnt update one clk after the qualifying valid; busy/not_zero are combinational from registers.
// Backpressure: none; valid is an accept strobe, every valid in RUN is counted unless abort is high.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   thresh, mode      terminal count and run mode, latched only when a run starts
//   start, abort      begin a run from IDLE / cancel a run (abort has priority)
//   valid             sample-accepted strobe
//   cnt, not_zero     sample index within the current frame, and cnt != 0
//   busy              high while running
//   full              one-cycle pulse after the terminal sample of a frame
//   frame_cnt         completed frames since the last start, wrapping
module fft_frame_counter
    import fft_cnt_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned FRM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] thresh,
    input  logic             mode,
    input  logic             start,
    input  logic             abort,
    input  logic             valid,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             not_zero,
    output logic             full,
    output logic [FRM_W-1:0] frame_cnt
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [FRM_W-1:0] frm_q,   frm_d;
    logic [CNT_W-1:0] thr_q,   thr_d;
    logic             mode_q,  mode_d;
    logic             full_q,  full_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frm_d   = frm_q;
        thr_d   = thr_q;
        mode_d  = mode_q;
        full_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            // A valid in the start cycle is deliberately not counted.
            if (start && !abort) begin
                state_d = ST_RUN;
                thr_d   = thresh;
                mode_d  = mode;
                cnt_d   = '0;
                frm_d   = '0;
            end
        end else begin
            if (abort) begin
                // Abort suppresses the full pulse even on a terminal valid;
                // the completed-frame count is kept for inspection.
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (valid) begin
                if (cnt_q == thr_q) begin
                    cnt_d  = '0;
                    full_d = 1'b1;
                    frm_d  = frm_q + FRM_W'(1);
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            frm_q   <= '0;
            thr_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            thr_q   <= thr_d;
            mode_q  <= mode_d;
            full_q  <= full_d;
        end
    end

    assign cnt       = cnt_q;
    assign busy      = (state_q == ST_RUN);
    assign not_zero  = |cnt_q;
    assign full      = full_q;
    assign frame_cnt = frm_q;

endmodule

// File: tb/tb_fft_frame_counter.sv
// Self-checking bench for fft_frame_counter: directed scenarios plus random stimulus
// against a sample-count reference model (frames = samples / (thresh+1)).
module tb_fft_frame_counter;

    localparam int CNT_W = 8;
    localparam int FRM_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] thresh;
    logic             mode;
    logic             start;
    logic             abort;
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             not_zero;
    logic             full;
    logic [FRM_W-1:0] frame_cnt;

    fft_frame_counter #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .thresh    (thresh),
        .mode      (mode),
        .start     (start),
        .abort     (abort),
        .valid     (valid),
        .cnt       (cnt),
        .busy      (busy),
        .not_zero  (not_zero),
        .full      (full),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: samples counted since the last start and run parameters.
    bit m_run;
    int m_n;
    int m_thr;
    bit m_mode;
    bit m_full;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
        return m_run ? (m_n % (m_thr + 1)) : 0;
    endfunction

    function automatic int exp_frm();
        return (m_n / (m_thr + 1)) % (1 << FRM_W);
    endfunction

    task automatic check_all();
        check_val("cnt",       32'(cnt),       32'(exp_cnt()));
        check_val("busy",      32'(busy),      32'(m_run));
        check_val("not_zero",  32'(not_zero),  32'(exp_cnt() != 0));
        check_val("full",      32'(full),      32'(m_full));
        check_val("frame_cnt", 32'(frame_cnt), 32'(exp_frm()));
    endtask

    task automatic model_step(input bit st, input bit ab, input bit vl, input int th, input bit md);
        m_full = 1'b0;
        if (!m_run) begin
            if (st && !ab) begin
                m_run  = 1'b1;
                m_n    = 0;
                m_thr  = th & ((1 << CNT_W) - 1);
                m_mode = md;
            end
        end else if (ab) begin
            m_run = 1'b0;
        end else if (vl) begin
            m_n++;
            if (m_n % (m_thr + 1) == 0) begin
                m_full = 1'b1;
                if (!m_mode) m_run = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_n    = 0;
        m_thr  = 0;
        m_mode = 1'b0;
        m_full = 1'b0;
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
    task automatic cyc(input bit st, input bit ab, input bit vl, input int th, input bit md);
        start  = st;
        abort  = ab;
        valid  = vl;
        thresh = CNT_W'(th);
        mode   = md;
        @(posedge clk);
        model_step(st, ab, vl, th, md);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; thresh = '0; mode = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        // Idle with valid and no start: nothing moves.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5, 1);

        // 256-sample one-shot frame.
        cyc(1, 0, 0, 255, 0);
        for (int i = 0; i < 256; i++) cyc(0, 0, 1, 255, 0);
        check_val("oneshot256_full", 32'(full), 1);
        check_val("oneshot256_frm",  32'(frame_cnt), 1);
        cyc(0, 0, 0, 255, 0);
        check_val("oneshot256_busy", 32'(busy), 0);

        // Continuous, thresh=3, 12 valids -> 3 frames, still busy.
        cyc(1, 0, 0, 3, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 3, 1);
        check_val("cont3_frm",  32'(frame_cnt), 3);
        check_val("cont3_busy", 32'(busy), 1);
        cyc(0, 1, 0, 3, 1);

        // thresh=0 continuous: full every valid, cnt stays 0.
        cyc(1, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1);
        check_val("thr0_full", 32'(full), 1);
        cyc(0, 1, 0, 0, 1);

        // Abort coincident with the terminal valid.
        cyc(1, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 3, 0);
        cyc(0, 1, 1, 3, 0);
        check_val("abort_full", 32'(full), 0);
        check_val("abort_frm",  32'(frame_cnt), 0);
        cyc(1, 1, 0, 3, 0);
        check_val("abort_start_busy", 32'(busy), 0);

        // Reset mid-run, then start with a coincident valid.
        cyc(1, 0, 0, 7, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 7, 0);
        async_reset();
        cyc(0, 0, 1, 7, 0);
        check_val("post_reset_full", 32'(full), 0);
        cyc(1, 0, 1, 7, 0);
        check_val("start_valid_cnt", 32'(cnt), 0);
        cyc(0, 1, 0, 7, 0);

        // Frame counter wrap with thresh changed mid-run.
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, (i < 3) ? 1 : 5, 1);
        check_val("wrap_frm", 32'(frame_cnt), 1);
        cyc(0, 1, 0, 5, 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 6)),
                    $urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
